fb_scanout: RTL and testbench

//   Read side of the 64x64x12b frame buffer that the sprite engine writes. After the

---
 rtl/fb_scanout.sv | 146 ++++++++++++++
 tb/tb_fb_scanout.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: reads a 64x64 frame in raster order, streams pixels on a
// valid/ready port through a 2-entry prefetch FIFO and accumulates a frame checksum.
module fb_scanout #(
    parameter int AW  = 12,
    parameter int DW  = 12,
    parameter int CSW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           FB_CEN,
    output logic           FB_WEN,
    output logic [AW-1:0]  FB_A,
    output logic [DW-1:0]  FB_D,
    input  logic [DW-1:0]  FB_Q,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic [DW-1:0]  pix_data,
    output logic [5:0]     pix_x,
    output logic [5:0]     pix_y,
    output logic           pix_last,
    output logic           busy,
    output logic           done,
    output logic [CSW-1:0] checksum
);

    // Pixel port: a pixel moves only in a cycle with pix_valid & pix_ready; while
    // pix_valid=1 and pix_ready=0 every pix_* output holds its value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  out_addr;
    logic           inflight;
    logic [1:0]     fifo_count;
    logic [DW-1:0]  fifo_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           pop;
    logic           issue;
    logic           scan_entry;
    logic [2:0]     credit;

    assign pop       = pix_valid & pix_ready;
    assign credit    = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign FB_CEN    = ~issue;
    assign FB_WEN    = 1'b1;
    assign FB_A      = rd_addr;
    assign FB_D      = '0;
    assign pix_valid = (fifo_count != 2'd0);
    assign pix_data  = fifo_mem[rd_ptr];
    assign pix_x     = out_addr[5:0];
    assign pix_y     = out_addr[11:6];
    assign pix_last  = (out_addr == {AW{1'b1}});
    assign busy      = (state == S_SCAN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        scan_entry = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_SCAN;
                    scan_entry = 1'b1;
                end
            end
            S_SCAN: begin
                // Only request while the data already owed fits in the 2-entry FIFO.
                if (credit < 3'd2) begin
                    issue = 1'b1;
                    if (rd_addr == {AW{1'b1}}) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && pix_last) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr    <= '0;
            out_addr   <= '0;
            checksum   <= '0;
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            inflight <= issue;
            if (scan_entry) begin
                rd_addr  <= '0;
                out_addr <= '0;
                checksum <= '0;
            end else begin
                if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                end
                if (pop) begin
                    out_addr <= out_addr + 1'b1;
                    checksum <= checksum + CSW'(pix_data);
                end
            end
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // FB_Q returns one cycle after the request, so the registered issue is the push.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= FB_Q;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inflight && !pop && (fifo_count == 2'd2)));

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: FB memory model, a per-cycle collector, and one task per scenario
// checking the streamed frame against a raster-order model of the memory contents.
module tb_fb_scanout;
  localparam int N = 4096;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        reset, start, pix_ready;
  logic        FB_CEN, FB_WEN, pix_valid, pix_last, busy, done;
  logic [11:0] FB_A, FB_D, FB_Q, pix_data;
  logic [5:0]  pix_x, pix_y;
  logic [15:0] checksum;

  fb_scanout dut (
    .clk(clk), .reset(reset), .start(start),
    .FB_CEN(FB_CEN), .FB_WEN(FB_WEN), .FB_A(FB_A), .FB_D(FB_D), .FB_Q(FB_Q),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [N];
  always @(posedge clk) if (!FB_CEN) FB_Q <= mem[FB_A];

  int total = 0;
  int bad = 0;

  // model and observations
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [5:0]  gx_q[$], gy_q[$];
  logic        glast_q[$];
  int reads, xfers, first_read, first_valid, done_cyc, reads_at_100;
  int hold_bad, addr_bad, max_out;
  logic        d1_done;
  logic [15:0] d1_cs, fin_cs;

  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < N; a++) exp_q.push_back(mem[a]);
  endtask

  function automatic logic [15:0] model_sum();
    int s = 0;
    foreach (exp_q[i]) s += int'(exp_q[i]);
    return s[15:0];
  endfunction

  function automatic int stream_diff();
    if (got_q.size() != exp_q.size())
      return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < N; i++)
      if (got_q[i] !== exp_q[i] || gx_q[i] !== 6'(i % 64) || gy_q[i] !== 6'(i / 64) ||
          glast_q[i] !== (i == N - 1)) return i;
    return -1;
  endfunction

  // mode: 0 ready=1, 1 toggle, 2 stall 100 cycles, 3 random, 4 random + starts while busy
  task automatic run_frame(input int mode, input int abort_at);
    logic pv, pr, pl;
    logic [11:0] pd;
    logic [5:0] px, py;
    got_q.delete(); gx_q.delete(); gy_q.delete(); glast_q.delete();
    reads = 0; xfers = 0; first_read = -1; first_valid = -1; done_cyc = -1;
    reads_at_100 = -1; hold_bad = 0; addr_bad = 0; max_out = 0;
    d1_done = 1'bx; d1_cs = 'x; fin_cs = 'x;
    pv = 1'b0; pr = 1'b0; pd = '0; px = '0; py = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1;
    pix_ready = (mode == 0);
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = (mode == 4) && busy && ($urandom_range(0, 5) == 0);
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = (k % 2 == 1);
        2: pix_ready = (k > 100);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 1) begin d1_done = done; d1_cs = checksum; end
      if (done) begin done_cyc = k; fin_cs = checksum; break; end
      if (!FB_CEN) begin
        if (FB_A !== 12'(reads)) addr_bad++;
        reads++;
        if (first_read < 0) first_read = k;
      end
      if (pix_valid && first_valid < 0) first_valid = k;
      if (pv && !pr && (!pix_valid || pix_data !== pd || pix_x !== px || pix_y !== py ||
          pix_last !== pl)) hold_bad++;
      pv = pix_valid; pr = pix_ready; pd = pix_data; px = pix_x; py = pix_y; pl = pix_last;
      if (pix_valid && pix_ready) begin
        got_q.push_back(pix_data); gx_q.push_back(pix_x);
        gy_q.push_back(pix_y); glast_q.push_back(pix_last);
        xfers++;
      end
      if (reads - xfers > max_out) max_out = reads - xfers;
      if (k == 100) reads_at_100 = reads;
      if (abort_at > 0 && xfers == abort_at) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (FB_CEN !== 1'b1 || FB_A !== 12'd0 || FB_WEN !== 1'b1 || FB_D !== 12'd0) begin
      bad++; $display("FAIL reset_fb got cen=%b a=%0d wen=%b d=%0d exp cen=1 a=0 wen=1 d=0",
                      FB_CEN, FB_A, FB_WEN, FB_D); end
    total++; if (pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_x !== 6'd0 || pix_y !== 6'd0) begin
      bad++; $display("FAIL reset_pix got v=%b l=%b x=%0d y=%0d exp all 0",
                      pix_valid, pix_last, pix_x, pix_y); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || checksum !== 16'd0) begin
      bad++; $display("FAIL reset_status got busy=%b done=%b cs=%h exp 0 0 0000",
                      busy, done, checksum); end
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    int d;
    for (int a = 0; a < N; a++) mem[a] = 12'(a);
    build_expected();
    run_frame(0, 0);
    d = stream_diff();
    total++; if (d != -1) begin bad++; $display("FAIL ramp_stream first_bad_index=%0d exp -1", d); end
    total++; if (first_read != 1) begin bad++; $display("FAIL ramp_first_read got=%0d exp=1", first_read); end
    total++; if (first_valid != 3) begin bad++; $display("FAIL ramp_first_valid got=%0d exp=3", first_valid); end
    total++; if (done_cyc != 4099) begin bad++; $display("FAIL ramp_done_cycle got=%0d exp=4099", done_cyc); end
    total++; if (fin_cs !== 16'hF800) begin bad++; $display("FAIL ramp_checksum got=%h exp=f800", fin_cs); end
    total++; if (reads != N || addr_bad != 0) begin
      bad++; $display("FAIL ramp_reads got=%0d addr_bad=%0d exp=%0d 0", reads, addr_bad, N); end
  endtask

  task automatic test_toggle();
    int d;
    run_frame(1, 0);
    d = stream_diff();
    total++; if (d != -1) begin bad++; $display("FAIL toggle_stream first_bad_index=%0d exp -1", d); end
    total++; if (reads != N) begin bad++; $display("FAIL toggle_reads got=%0d exp=%0d", reads, N); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL toggle_hold got=%0d exp=0", hold_bad); end
    total++; if (max_out > 2) begin bad++; $display("FAIL toggle_outstanding got=%0d exp<=2", max_out); end
  endtask

  task automatic test_stall100();
    int d;
    run_frame(2, 0);
    d = stream_diff();
    total++; if (reads_at_100 != 2) begin bad++; $display("FAIL stall_reads got=%0d exp=2", reads_at_100); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", hold_bad); end
    total++; if (d != -1) begin bad++; $display("FAIL stall_stream first_bad_index=%0d exp -1", d); end
  endtask

  task automatic test_background();
    int d, nlast;
    for (int a = 0; a < N; a++) mem[a] = 12'hCF0;
    build_expected();
    run_frame(3, 0);
    d = stream_diff();
    nlast = 0;
    foreach (glast_q[i]) if (glast_q[i]) nlast++;
    total++; if (d != -1) begin bad++; $display("FAIL bg_stream first_bad_index=%0d exp -1", d); end
    total++; if (fin_cs !== model_sum() || fin_cs !== 16'h0000) begin
      bad++; $display("FAIL bg_checksum got=%h exp=0000", fin_cs); end
    total++; if (nlast != 1) begin bad++; $display("FAIL bg_last_count got=%0d exp=1", nlast); end
  endtask

  task automatic test_start_ignored();
    int d;
    for (int a = 0; a < N; a++) mem[a] = 12'($urandom);
    build_expected();
    run_frame(4, 0);
    d = stream_diff();
    total++; if (d != -1) begin bad++; $display("FAIL startign_stream first_bad_index=%0d exp -1", d); end
    total++; if (reads != N || max_out > 2) begin
      bad++; $display("FAIL startign_reads got=%0d out=%0d exp=%0d <=2", reads, max_out, N); end
    total++; if (fin_cs !== model_sum()) begin
      bad++; $display("FAIL startign_checksum got=%h exp=%h", fin_cs, model_sum()); end
  endtask

  task automatic test_reset_mid();
    int d, leaks;
    for (int a = 0; a < N; a++) mem[a] = 12'(a);
    build_expected();
    run_frame(0, 2000);
    total++; if (xfers != 2000) begin bad++; $display("FAIL abort_reach got=%0d exp=2000", xfers); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (FB_CEN !== 1'b1 || FB_A !== 12'd0 || pix_valid !== 1'b0 || pix_last !== 1'b0 ||
                 pix_x !== 6'd0 || pix_y !== 6'd0 || busy !== 1'b0 || done !== 1'b0 ||
                 checksum !== 16'd0) begin
      bad++; $display("FAIL abort_outputs got cen=%b a=%0d v=%b x=%0d y=%0d busy=%b cs=%h exp reset values",
                      FB_CEN, FB_A, pix_valid, pix_x, pix_y, busy, checksum); end
    @(negedge clk);
    reset = 1'b0;
    leaks = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (!FB_CEN || pix_valid || busy) leaks++;
    end
    total++; if (leaks != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", leaks); end
    run_frame(0, 0);
    d = stream_diff();
    total++; if (d != -1 || done_cyc != 4099) begin
      bad++; $display("FAIL rescan got first_bad=%0d done=%0d exp -1 4099", d, done_cyc); end
  endtask

  task automatic test_back_to_back();
    int d;
    @(negedge clk); #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_precond got done=%b exp=1", done); end
    for (int a = 0; a < N; a++) mem[a] = 12'($urandom);
    build_expected();
    run_frame(3, 0);
    d = stream_diff();
    total++; if (d1_done !== 1'b0 || d1_cs !== 16'd0) begin
      bad++; $display("FAIL b2b_clear got done=%b cs=%h exp 0 0000", d1_done, d1_cs); end
    total++; if (d != -1) begin bad++; $display("FAIL b2b_stream first_bad_index=%0d exp -1", d); end
    total++; if (fin_cs !== model_sum()) begin
      bad++; $display("FAIL b2b_checksum got=%h exp=%h", fin_cs, model_sum()); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_toggle();
    test_stall100();
    test_background();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
